// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types for the prescaled multi-channel compare timer
package timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_e;

endpackage

// File: rtl/prescaled_multitimer_tick_prescaler.sv
// rtl/prescaled_multitimer_tick_prescaler.sv - clock divider producing a tick every div_i+1 enabled clocks
module tick_prescaler #(
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                      clock_i,
    input  logic                      reset_n_i,
    input  logic                      clear_i,
    input  logic                      enable_i,
    input  logic [PRESCALE_WIDTH-1:0] div_i,
    output logic                      tick_o
);

    logic [PRESCALE_WIDTH-1:0] cnt_q;
    logic [PRESCALE_WIDTH-1:0] cnt_d;

    assign tick_o = enable_i && !clear_i && (cnt_q == div_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prescaled_multitimer.sv
// rtl/prescaled_multitimer.sv - multi-channel compare timer with prescaler, one-shot/periodic modes and stop
module prescaled_multitimer
    import timer_pkg::*;
#(
    parameter int TIMER_WIDTH    = 8,
    parameter int CHANNELS       = 4,
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                      clock_i,
    input  logic                      reset_n_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic [TIMER_WIDTH-1:0]    period_i,
    input  logic                      periodic_i,
    input  logic [TIMER_WIDTH-1:0]    compare_i [CHANNELS],
    input  logic                      start_i,
    input  logic                      stop_i,
    output logic                      running_o,
    output logic [TIMER_WIDTH-1:0]    count_o,
    output logic [CHANNELS-1:0]       expired_o,
    output logic [CHANNELS-1:0]       strobe_o,
    output logic                      wrap_o
);

    timer_state_e              state_q, state_d;
    logic                      start_q;
    logic [TIMER_WIDTH-1:0]    count_q, count_d;
    logic [TIMER_WIDTH-1:0]    period_q, period_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      periodic_q, periodic_d;
    logic                      wrap_q, wrap_d;

    logic                      start_edge;
    logic                      running;
    logic                      tick;
    logic                      advance;
    logic                      at_period;
    logic [TIMER_WIDTH-1:0]    count_inc;

    assign start_edge = start_i && !start_q;
    assign running    = (state_q == RUN);
    assign at_period  = (count_q == period_q);
    assign count_inc  = count_q + TIMER_WIDTH'(1);
    // A start edge outranks stop; stop suppresses the tick of its own cycle.
    assign advance    = running && !start_edge && !stop_i && tick;

    tick_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_tick_prescaler (
        .clock_i  (clock_i),
        .reset_n_i(reset_n_i),
        .clear_i  (start_edge),
        .enable_i (running),
        .div_i    (prescale_q),
        .tick_o   (tick)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        periodic_d = periodic_q;
        wrap_d     = 1'b0;
        if (start_edge) begin
            state_d    = RUN;
            count_d    = '0;
            period_d   = period_i;
            prescale_d = prescale_i;
            periodic_d = periodic_i;
        end else if (running && stop_i) begin
            state_d = IDLE;
        end else if (advance) begin
            if (at_period) begin
                wrap_d = 1'b1;
                if (periodic_q) begin
                    count_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                count_d = count_inc;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            count_q    <= '0;
            period_q   <= '1;
            prescale_q <= '0;
            periodic_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_i;
            count_q    <= count_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            periodic_q <= periodic_d;
            wrap_q     <= wrap_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
        logic [TIMER_WIDTH-1:0] cmp_q, cmp_d;
        logic                   exp_q, exp_d;
        logic                   stb_q, stb_d;

        always_comb begin
            cmp_d = cmp_q;
            exp_d = exp_q;
            stb_d = 1'b0;
            if (start_edge) begin
                cmp_d = compare_i[g];
                exp_d = (compare_i[g] == '0);
                stb_d = exp_d;
            end else if (advance) begin
                if (at_period) begin
                    // Wrap clears every channel; zero compares re-expire at once.
                    if (periodic_q) begin
                        exp_d = (cmp_q == '0);
                        stb_d = exp_d;
                    end
                end else if (count_inc >= cmp_q) begin
                    exp_d = 1'b1;
                    stb_d = !exp_q;
                end
            end
        end

        always_ff @(posedge clock_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                cmp_q <= '1;
                exp_q <= 1'b0;
                stb_q <= 1'b0;
            end else begin
                cmp_q <= cmp_d;
                exp_q <= exp_d;
                stb_q <= stb_d;
            end
        end

        assign expired_o[g] = exp_q;
        assign strobe_o[g]  = stb_q;
    end

    assign running_o = running;
    assign count_o   = count_q;
    assign wrap_o    = wrap_q;

endmodule

// File: tb/tb_prescaled_multitimer.sv
// tb/tb_prescaled_multitimer.sv - randomized self-checking bench for prescaled_multitimer
module tb_prescaled_multitimer;

    localparam int TW = 8;
    localparam int CH = 4;
    localparam int PW = 4;

    logic          clock_i   = 1'b0;
    logic          reset_n_i = 1'b0;
    logic [PW-1:0] prescale_i;
    logic [TW-1:0] period_i;
    logic          periodic_i;
    logic [TW-1:0] compare_i [CH];
    logic          start_i;
    logic          stop_i;
    logic          running_o;
    logic [TW-1:0] count_o;
    logic [CH-1:0] expired_o;
    logic [CH-1:0] strobe_o;
    logic          wrap_o;

    int total = 0;
    int bad   = 0;

    // Reference model: position is derived from clocks elapsed since start.
    bit          m_run;
    bit          m_start_prev;
    bit          m_periodic;
    int          m_pre, m_per, m_cyc, m_ticks, m_count;
    int          m_cmp [CH];
    bit [CH-1:0] m_exp, m_stb;
    bit          m_wrap;

    prescaled_multitimer #(
        .TIMER_WIDTH   (TW),
        .CHANNELS      (CH),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .prescale_i(prescale_i),
        .period_i  (period_i),
        .periodic_i(periodic_i),
        .compare_i (compare_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .running_o (running_o),
        .count_o   (count_o),
        .expired_o (expired_o),
        .strobe_o  (strobe_o),
        .wrap_o    (wrap_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_start_prev = 0; m_periodic = 0;
        m_pre = 0; m_per = 255; m_cyc = 0; m_ticks = 0; m_count = 0;
        for (int i = 0; i < CH; i++) m_cmp[i] = 255;
        m_exp = '0; m_stb = '0; m_wrap = 0;
    endtask

    task automatic model_step();
        bit edge_seen;
        edge_seen    = start_i && !m_start_prev;
        m_start_prev = start_i;
        m_stb  = '0;
        m_wrap = 0;
        if (edge_seen) begin
            m_pre = int'(prescale_i); m_per = int'(period_i); m_periodic = periodic_i;
            m_cyc = 0; m_ticks = 0; m_count = 0; m_run = 1;
            for (int i = 0; i < CH; i++) begin
                m_cmp[i] = int'(compare_i[i]);
                m_exp[i] = (m_cmp[i] == 0);
            end
            m_stb = m_exp;
        end else if (m_run) begin
            if (stop_i) begin
                m_run = 0;
            end else begin
                m_cyc++;
                if (m_cyc % (m_pre + 1) == 0) begin
                    m_ticks++;
                    if (m_periodic && (m_ticks % (m_per + 1) == 0)) begin
                        m_wrap = 1; m_count = 0;
                        for (int i = 0; i < CH; i++) m_exp[i] = (m_cmp[i] == 0);
                        m_stb = m_exp;
                    end else if (!m_periodic && m_ticks == m_per + 1) begin
                        m_wrap = 1; m_run = 0;
                    end else begin
                        m_count = m_periodic ? m_ticks % (m_per + 1) : m_ticks;
                        for (int i = 0; i < CH; i++) begin
                            if (m_cmp[i] <= m_count && !m_exp[i]) begin
                                m_exp[i] = 1; m_stb[i] = 1;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        check_eq("running", 32'(running_o), 32'(m_run));
        check_eq("count",   32'(count_o),   32'(m_count));
        check_eq("expired", 32'(expired_o), 32'(m_exp));
        check_eq("strobe",  32'(strobe_o),  32'(m_stb));
        check_eq("wrap",    32'(wrap_o),    32'(m_wrap));
    endtask

    task automatic cycle();
        @(posedge clock_i);
        if (reset_n_i) model_step();
        @(negedge clock_i);
        check_all();
    endtask

    task automatic do_reset(input bit start_level);
        #2 reset_n_i = 1'b0;
        model_reset();
        #1 check_all();
        start_i = start_level;
        cycle();
        cycle();
        #2 reset_n_i = 1'b1;
    endtask

    task automatic randomize_inputs();
        int p;
        p          = ($urandom % 4 == 0) ? int'($urandom % 256) : int'($urandom % 13);
        period_i   = TW'(p);
        prescale_i = ($urandom % 5 == 0) ? PW'($urandom % 16) : PW'($urandom % 3);
        periodic_i = 1'($urandom % 2);
        for (int i = 0; i < CH; i++) compare_i[i] = TW'($urandom % (p + 4));
        start_i    = ($urandom % 10 == 0);
        stop_i     = ($urandom % 25 == 0);
    endtask

    initial begin
        model_reset();
        prescale_i = '0; period_i = '0; periodic_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
        for (int i = 0; i < CH; i++) compare_i[i] = '0;
        @(negedge clock_i);
        check_all();
        check_eq("reset_count", 32'(count_o), 32'd0);
        check_eq("reset_running", 32'(running_o), 32'd0);
        #2 reset_n_i = 1'b1;

        // One-shot scenario with compares {0,3,5,9}, period 7, no prescale.
        compare_i[0] = 8'd0; compare_i[1] = 8'd3; compare_i[2] = 8'd5; compare_i[3] = 8'd9;
        period_i = 8'd7; periodic_i = 1'b0; prescale_i = '0; start_i = 1'b1;
        cycle();
        check_eq("t1_strobe0_at_k", 32'(strobe_o), 32'h1);
        start_i = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            cycle();
            if (c == 3) check_eq("t1_strobe1", 32'(strobe_o), 32'h2);
            if (c == 5) check_eq("t1_strobe2", 32'(strobe_o), 32'h4);
            if (c == 8) check_eq("t1_wrap", 32'(wrap_o), 32'h1);
        end
        check_eq("t1_count_hold", 32'(count_o), 32'd7);
        check_eq("t1_idle", 32'(running_o), 32'd0);
        check_eq("t1_expired", 32'(expired_o), 32'h7);

        // Periodic period 3: wrap every 4 clocks.
        compare_i[0] = 8'd0; compare_i[1] = 8'd2; period_i = 8'd3; periodic_i = 1'b1;
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            cycle();
            if (c == 4 || c == 8) check_eq("t3_wrap", 32'(wrap_o), 32'h1);
            if (c == 6) check_eq("t3_strobe1", 32'(strobe_o[1]), 32'h1);
        end

        // Reset while running with expired set, start held at release.
        do_reset(1'b1);
        cycle();
        check_eq("t6_restart", 32'(running_o), 32'd1);

        for (int n = 0; n < 5000; n++) begin
            randomize_inputs();
            if ($urandom % 300 == 0) do_reset(1'($urandom % 2));
            else cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
